boid_frame_reader: RTL
======================

BOID_FRAME_READER -- requirements
Module: boid_frame_reader

Interface
REQ-001 The block SHALL have the following parameters.
- VIDEO_WIDTH, default 640: pixels per line.
- VIDEO_HEIGHT, default 480: lines per frame.
- PIXEL_ADDRESS_WIDTH, default 19: width of the display RAM address.

REQ-002 The block SHALL have the following ports.
- clock, input, 1: single clock for all logic.
- reset, input, 1: synchronous, active-high.
- pixel_x, input, 10: VGA scan column.
- pixel_y, input, 9: VGA scan row.
- active, input, 1: VGA visible-area flag.
- screenEnd, input, 1: one-cycle pulse at end of frame.
- writer_done, input, 1: one-cycle pulse; the boid writer has finished filling the back buffer.
- read_addr, output, PIXEL_ADDRESS_WIDTH: display RAM read address (registered).
- read_buf, output, 1: buffer currently displayed.
- write_buf, output, 1: buffer the writer may fill; always ~read_buf.
- read_data, input, 1: RAM synchronous-read data, valid one cycle after read_addr.
- pixel_out, output, 1: boid-present bit aligned to pixel_valid.
- pixel_valid, output, 1: pixel_out corresponds to an in-range visible pixel.
- clear_back, output, 1: one-cycle pulse requesting a clear of write_buf.
- swap_count, output, 8: number of completed buffer swaps.
- missed_count, output, 8: number of frames that ended with no new frame ready.

Function
REQ-003 read_addr SHALL be registered as pixel_x + VIDEO_WIDTH*pixel_y. The multiply SHALL be built from shifts and adds (y<<9 + y<<7 for 640), with no DSP inference required.
REQ-004 If pixel_x >= VIDEO_WIDTH, pixel_y >= VIDEO_HEIGHT, or active=0, the block SHALL force read_addr to 0 and mark that pixel invalid.
REQ-005 The pipeline latency SHALL be fixed at 3 cycles from inputs to outputs:
- cycle N: pixel_x, pixel_y and active are sampled.
- N+1: read_addr is presented.
- N+2: read_data returns.
- N+3: pixel_out and pixel_valid are registered.
REQ-006 pixel_out SHALL equal read_data AND the delayed valid flag. pixel_out SHALL be 0 whenever pixel_valid=0.
REQ-007 The FSM SHALL have three states: WAIT_FIRST, SCAN and SWAP.
REQ-008 WAIT_FIRST: entered on reset. The FSM SHALL move to SCAN on the first screenEnd without swapping. pixel_valid SHALL be held 0 in this state.
REQ-009 In SCAN, a frame_ready flag SHALL be set by writer_done.
REQ-010 In SCAN, screenEnd with frame_ready=1 SHALL move the FSM to SWAP.
REQ-011 In SCAN, screenEnd with frame_ready=0 SHALL leave the FSM in SCAN and increment missed_count, saturating at 255.
REQ-012 SWAP SHALL last exactly one cycle. In that cycle the block SHALL:
- toggle read_buf;
- clear frame_ready;
- increment swap_count, wrapping 255 to 0;
- pulse clear_back=1.
The FSM SHALL then return to SCAN.
REQ-013 If writer_done and screenEnd arrive in the same cycle in SCAN, the block SHALL count that frame as ready and go to SWAP.
REQ-014 writer_done during SWAP or WAIT_FIRST SHALL set frame_ready for the next frame and SHALL NOT be lost.
REQ-015 A repeated writer_done while frame_ready=1 SHALL have no further effect.
REQ-016 A screenEnd arriving during SWAP SHALL be ignored. It SHALL NOT increment missed_count.
REQ-017 read_buf SHALL change only in SWAP. The pixel pipeline SHALL NOT be flushed on a swap; in-flight pixels complete normally.

Reset
REQ-018 On reset=1 at a clock edge, the following SHALL hold on the next cycle:
- state = WAIT_FIRST;
- read_buf = 0 and write_buf = 1;
- frame_ready = 0;
- read_addr = 0;
- pixel_out = 0 and pixel_valid = 0;
- clear_back = 0;
- swap_count = 0 and missed_count = 0;
- all pipeline valid bits = 0.
REQ-019 Reset asserted mid-frame or during SWAP SHALL abort any pending swap. No clear_back pulse SHALL be emitted in that case.

Verification
REQ-020 Address and latency: pixel_x=5, pixel_y=10, active=1 at cycle N. Required: read_addr=6405 at N+1. With read_data=1 at N+2, pixel_out=1 and pixel_valid=1 at N+3.
REQ-021 Out of range: pixel_x=640, pixel_y=0, active=1, read_data=1. Required: read_addr=0 at N+1, and pixel_valid=0 and pixel_out=0 at N+3. Repeat with pixel_y=480 and with active=0; same result.
REQ-022 Swap: release reset, then screenEnd, then writer_done, then screenEnd. Required after the second screenEnd: one-cycle SWAP with clear_back=1; then read_buf=1, write_buf=0, swap_count=1, missed_count=0.
REQ-023 Missed frames: after reaching SCAN, issue 300 screenEnd pulses with no writer_done. Required: missed_count=255 (saturated), swap_count=0, read_buf unchanged.
REQ-024 Simultaneous and wrap: writer_done and screenEnd in the same cycle. Required: swap occurs. Repeat 256 swaps; required: swap_count wraps to 0 and read_buf ends at its starting value.
REQ-025 Reset mid-operation: assert reset on the cycle the FSM enters SWAP. Required on the next cycle: all REQ-018 values, and clear_back never high.

Source files
------------

// File: rtl/boid_frame_reader.sv
// Display-side reader for a double-buffered boid frame store: streams VGA pixel
// addresses into the front buffer and swaps buffers when the writer has a frame ready.
module boid_frame_reader #(
    parameter int unsigned VIDEO_WIDTH         = 640,
    parameter int unsigned VIDEO_HEIGHT        = 480,
    parameter int unsigned PIXEL_ADDRESS_WIDTH = 19
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [9:0]                     pixel_x,
    input  logic [8:0]                     pixel_y,
    input  logic                           active,
    input  logic                           screenEnd,
    input  logic                           writer_done,
    output logic [PIXEL_ADDRESS_WIDTH-1:0] read_addr,
    output logic                           read_buf,
    output logic                           write_buf,
    input  logic                           read_data,
    output logic                           pixel_out,
    output logic                           pixel_valid,
    output logic                           clear_back,
    output logic [7:0]                     swap_count,
    output logic [7:0]                     missed_count
);

    localparam int unsigned AW = PIXEL_ADDRESS_WIDTH;
    localparam logic [AW-1:0] WIDTH_MUL = AW'(VIDEO_WIDTH);
    localparam logic [10:0]   X_LIMIT   = 11'(VIDEO_WIDTH);
    localparam logic [9:0]    Y_LIMIT   = 10'(VIDEO_HEIGHT);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        SCAN       = 2'd1,
        SWAP       = 2'd2
    } state_t;

    state_t          state_q;
    logic            frame_ready_q;
    logic            read_buf_q;
    logic            write_buf_q;
    logic            clear_back_q;
    logic [7:0]      swap_count_q;
    logic [7:0]      missed_count_q;

    logic [AW-1:0]   read_addr_q;
    logic [AW-1:0]   read_addr_d;
    logic [AW-1:0]   row_base_c;
    logic            in_range_c;
    logic            valid_s1_q;
    logic            valid_s2_q;
    logic            pixel_valid_q;
    logic            pixel_valid_d;
    logic            pixel_out_q;

    // y * VIDEO_WIDTH as a sum of shifted copies of y (set bits of the constant only)
    always_comb begin
        row_base_c = '0;
        for (int i = 0; i < int'(AW); i++) begin
            if (WIDTH_MUL[i]) begin
                row_base_c = row_base_c + (AW'(pixel_y) << i);
            end
        end
    end

    always_comb begin
        in_range_c    = active && ({1'b0, pixel_x} < X_LIMIT) && ({1'b0, pixel_y} < Y_LIMIT);
        read_addr_d   = in_range_c ? (AW'(pixel_x) + row_base_c) : '0;
        pixel_valid_d = valid_s2_q && (state_q != WAIT_FIRST);
    end

    // Three-stage pixel pipeline: address, RAM read, output; never flushed by a swap
    always_ff @(posedge clock) begin
        if (reset) begin
            read_addr_q   <= '0;
            valid_s1_q    <= 1'b0;
            valid_s2_q    <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_out_q   <= 1'b0;
        end else begin
            read_addr_q   <= read_addr_d;
            valid_s1_q    <= in_range_c;
            valid_s2_q    <= valid_s1_q;
            pixel_valid_q <= pixel_valid_d;
            pixel_out_q   <= read_data && pixel_valid_d;
        end
    end

    // Buffer-swap control; swap effects register on the edge leaving SWAP so a
    // reset during SWAP cancels them, including the clear_back pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= WAIT_FIRST;
            frame_ready_q  <= 1'b0;
            read_buf_q     <= 1'b0;
            write_buf_q    <= 1'b1;
            clear_back_q   <= 1'b0;
            swap_count_q   <= 8'd0;
            missed_count_q <= 8'd0;
        end else begin
            clear_back_q <= 1'b0;
            case (state_q)
                WAIT_FIRST: begin
                    if (writer_done) begin
                        frame_ready_q <= 1'b1;
                    end
                    if (screenEnd) begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (screenEnd) begin
                        if (frame_ready_q || writer_done) begin
                            frame_ready_q <= 1'b1;
                            state_q       <= SWAP;
                        end else if (missed_count_q != 8'hFF) begin
                            missed_count_q <= missed_count_q + 8'd1;
                        end
                    end else if (writer_done) begin
                        frame_ready_q <= 1'b1;
                    end
                end
                SWAP: begin
                    read_buf_q    <= ~read_buf_q;
                    write_buf_q   <= ~write_buf_q;
                    frame_ready_q <= writer_done;
                    swap_count_q  <= swap_count_q + 8'd1;
                    clear_back_q  <= 1'b1;
                    state_q       <= SCAN;
                end
                default: begin
                    state_q <= WAIT_FIRST;
                end
            endcase
        end
    end

    assign read_addr    = read_addr_q;
    assign read_buf     = read_buf_q;
    assign write_buf    = write_buf_q;
    assign pixel_out    = pixel_out_q;
    assign pixel_valid  = pixel_valid_q;
    assign clear_back   = clear_back_q;
    assign swap_count   = swap_count_q;
    assign missed_count = missed_count_q;

endmodule
